led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
- Downstream consumer of the board's periodic tick generator (the 50 MHz divide-by-50,000,000 stage).
- Each tick advances one of four LED animation patterns and drives the green LED bank (LEDG) directly.
- Replaces the fixed alternate-blink behaviour with a selectable, pausable sequencer.

Parameters:
- WIDTH, 8, number of LEDs driven; legal values are 2 to 32.
- INIT_PATTERN, 8'b01010101 (WIDTH bits), BLINK start value and reset value of led.
- TICK_DIV, 50000000, internal tick period in clk cycles; used only with LED_SEQ_TICKGEN_EN.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-high reset.
- tick  in  1  step strobe from the upstream divider; every cycle sampled high counts as one tick.
- mode  in  2  requested pattern: 00 BLINK, 01 SHIFT, 10 BOUNCE, 11 FILL.
- pause  in  1  1 = freeze the sequencer.
- led  out  WIDTH  registered LED pattern, to LEDG.
- cur_mode  out  2  currently active pattern.
- wrap  out  1  one-cycle pulse when the active pattern completes a full period.

Behaviour:
- Reset (synchronous, highest priority over tick, mode and pause):
  - led=INIT_PATTERN, cur_mode=00, dir=left, step=0, wrap=0.
- All outputs are registered. A tick sampled at edge N produces its led/wrap update visible after edge N, i.e. 1-cycle latency.
- Effective tick = tick & ~pause. On cycles with no effective tick, all state holds and wrap=0.
- mode is sampled only on an effective tick. If mode != cur_mode:
  - cur_mode <= mode, step <= 0, wrap <= 0.
  - led loads the start value for the new mode: BLINK INIT_PATTERN, SHIFT 1, BOUNCE 1 (dir=left), FILL 0.
  - No pattern advance happens on that tick.
- If mode == cur_mode, an effective tick advances the pattern:
  - BLINK: led <= ~led. Period 2 ticks. wrap on the tick that returns led to INIT_PATTERN.
  - SHIFT: rotate left by 1 (MSB wraps to bit0). Period WIDTH ticks. wrap on the tick that returns led to 1.
  - BOUNCE: one-hot moves in dir.
    - At bit WIDTH-1, dir <= right; at bit0, dir <= left. The reversal is applied in the same tick the end bit is reached.
    - Period 2*(WIDTH-1) ticks. wrap on the tick that returns led to bit0.
  - FILL: led <= {led[WIDTH-2:0],1'b1} until all ones; the next tick sets led <= 0. Period WIDTH+1 ticks. wrap on the tick that sets led to 0.
- step counter is internal, sized for 2*WIDTH, and wraps to 0 together with the wrap pulse.
- tick held high for K cycles gives K advances. No edge detection is performed.
- pause=1 ignores mode changes as well. A pending mode change applies on the first effective tick after pause drops.
- Reset asserted mid-pattern aborts immediately. The pre-reset mode is not retained.
- Any illegal state is unreachable; a default branch recovers to the reset values.

Optional Feature:
- Macro LED_SEQ_TICKGEN_EN.
- Defined:
  - An internal counter runs 0..TICK_DIV-1 and is cleared by reset.
  - It emits an internal tick for one cycle when it reaches TICK_DIV-1, then returns to 0.
  - The tick port is ignored; pause gates the internal tick the same way.
- Undefined:
  - No counter logic is present and the tick port drives the sequencer.
- Port list is identical in both builds.

Test Plan:
- Reset, mode=00, 3 single-cycle ticks: led goes 0x55 -> 0xAA -> 0x55 -> 0xAA. wrap pulses only on the 2nd tick. Each update appears 1 cycle after its tick.
- mode=01, then 9 ticks:
  - Tick 1 loads 0x01 with no wrap.
  - Ticks 2-9 give 0x02,0x04,...,0x80,0x01.
  - wrap pulses with the final 0x01. cur_mode=01.
- mode=10, 15 ticks:
  - Loads 0x01, then 0x02..0x80 over 7 ticks, then 0x40..0x01 over 7 ticks.
  - wrap pulses on the return to 0x01 (tick 15).
  - No duplicated 0x80 at the turn.
- mode=11, 10 ticks:
  - Loads 0x00, then 0x01,0x03,0x07,...,0xFF, then 0x00.
  - wrap pulses on the final 0x00.
- In SHIFT at 0x10:
  - pause=1, 5 ticks, mode changed to 11: led stays 0x10 and cur_mode stays 01.
  - Release pause, 1 tick: led=0x00 and cur_mode=11.
  - Reset asserted together with a tick: next cycle led=0x55, cur_mode=00, wrap=0.
- Build with LED_SEQ_TICKGEN_EN, TICK_DIV=4, mode=00, tick port held 0:
  - led toggles 0x55/0xAA every 4 cycles; first toggle 4 cycles after reset release.
  - Driving tick=1 has no effect.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
// Sequencer control/status bundle: tick/mode/pause in, registered led/cur_mode/wrap out.
interface led_pattern_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             tick;
    logic [1:0]       mode;
    logic             pause;
    logic [WIDTH-1:0] led;
    logic [1:0]       cur_mode;
    logic             wrap;

    modport master (output tick, output mode, output pause,
                    input  led,  input  cur_mode, input wrap);
    modport slave  (input  tick, input  mode, input  pause,
                    output led,  output cur_mode, output wrap);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Tick-stepped LED animator (BLINK/SHIFT/BOUNCE/FILL), all outputs registered, 1-cycle latency.
// Define LED_SEQ_TICKGEN_EN to replace the tick port with an internal TICK_DIV-cycle divider.
module led_pattern_sequencer #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'(8'b01010101),
    parameter int               TICK_DIV     = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    led_pattern_sequencer_if.slave  seq
);
    typedef enum logic [1:0] {
        MODE_BLINK  = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int SW = $clog2(2 * WIDTH + 1);
    // Step value on which each pattern completes its period.
    localparam logic [SW-1:0] BLINK_LAST  = SW'(1);
    localparam logic [SW-1:0] SHIFT_LAST  = SW'(WIDTH - 1);
    localparam logic [SW-1:0] BOUNCE_LAST = SW'(2 * WIDTH - 3);
    localparam logic [SW-1:0] FILL_LAST   = SW'(WIDTH);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_t            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [SW-1:0]    step_q, step_d;
    logic             wrap_q, wrap_d;
    logic [SW-1:0]    last;
    logic             eff_tick;

`ifdef LED_SEQ_TICKGEN_EN
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] div_q;
    logic          gen_tick;
    logic          unused_tick;

    assign gen_tick    = (div_q == CW'(TICK_DIV - 1));
    assign unused_tick = seq.tick;

    always_ff @(posedge clk) begin
        if (reset || gen_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + CW'(1);
        end
    end

    assign eff_tick = gen_tick & ~seq.pause;
`else
    localparam int unused_tick_div = TICK_DIV;

    assign eff_tick = seq.tick & ~seq.pause;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_BLINK;
            dir_q  <= DIR_LEFT;
            led_q  <= INIT_PATTERN;
            step_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        step_d = step_q;
        wrap_d = 1'b0;
        last   = BLINK_LAST;
        if (eff_tick) begin
            if (seq.mode != mode_q) begin
                // A mode switch only loads the new start value; advancing waits for the next tick.
                mode_d = mode_t'(seq.mode);
                dir_d  = DIR_LEFT;
                step_d = '0;
                case (mode_t'(seq.mode))
                    MODE_BLINK:  led_d = INIT_PATTERN;
                    MODE_SHIFT:  led_d = ONE;
                    MODE_BOUNCE: led_d = ONE;
                    default:     led_d = '0;
                endcase
            end else begin
                step_d = step_q + SW'(1);
                case (mode_q)
                    MODE_BLINK: begin
                        led_d = ~led_q;
                        last  = BLINK_LAST;
                    end
                    MODE_SHIFT: begin
                        led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                        last  = SHIFT_LAST;
                    end
                    MODE_BOUNCE: begin
                        // Direction flips on the tick that lands on an end bit, so the end is never repeated.
                        if (dir_q == DIR_LEFT) begin
                            led_d = {led_q[WIDTH-2:0], 1'b0};
                            if (led_d[WIDTH-1]) dir_d = DIR_RIGHT;
                        end else begin
                            led_d = {1'b0, led_q[WIDTH-1:1]};
                            if (led_d[0]) dir_d = DIR_LEFT;
                        end
                        last = BOUNCE_LAST;
                    end
                    MODE_FILL: begin
                        led_d = (&led_q) ? '0 : {led_q[WIDTH-2:0], 1'b1};
                        last  = FILL_LAST;
                    end
                    default: begin
                        mode_d = MODE_BLINK;
                        dir_d  = DIR_LEFT;
                        led_d  = INIT_PATTERN;
                        step_d = '0;
                        last   = BLINK_LAST;
                    end
                endcase
                if (step_q >= last) begin
                    step_d = '0;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        seq.led      = led_q;
        seq.cur_mode = mode_q;
        seq.wrap     = wrap_q;
    end
endmodule
